// File: rtl/hex_scan_ctrl_if.sv
// Load-side bus of the multiplexed hex display controller: new digit contents,
// digit mask and blanking flag go in; commit acknowledge and pending status come back.
interface hex_scan_ctrl_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] data_i;
  logic [DIGITS-1:0]   mask_i;
  logic                lzb_i;
  logic                load_i;
  logic                load_ack_o;
  logic                pending_o;

  modport master (
    output data_i, mask_i, lzb_i, load_i,
    input  load_ack_o, pending_o
  );

  modport slave (
    input  data_i, mask_i, lzb_i, load_i,
    output load_ack_o, pending_o
  );
endinterface

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed common-anode hex display scanner with dead-time blanking,
// per-digit masking, leading-zero blanking and frame-synchronous content commit.
module hex_scan_ctrl #(
  parameter int DIGITS   = 8,
  parameter int PRESCALE = 100000,
  parameter int DEAD     = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  hex_scan_ctrl_if.slave    bus,
  output logic              frame_o,
  output logic [6:0]        seg_o,
  output logic [DIGITS-1:0] an_o
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] DEAD_END = PW'(DEAD);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic          presc_wrap;
  logic          boundary;

  logic [4*DIGITS-1:0] stg_data, sh_data;
  logic [DIGITS-1:0]   stg_mask, sh_mask;
  logic                stg_lzb, sh_lzb;
  logic                pending;

  logic [DIGITS-1:0] blank;
  logic              zero_run;
  logic [3:0]        nib;
  logic              shown;
  logic [DIGITS-1:0] an_d;
  logic [6:0]        seg_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  assign presc_wrap = (presc == PRE_LAST);
  assign boundary   = presc_wrap && (idx == IDX_LAST);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc_wrap) begin
      presc <= '0;
      idx   <= boundary ? '0 : idx + IW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Load handshake: load_i is a single-cycle strobe with no back-pressure; the
  // captured values are held (pending_o=1) until the next frame wrap, where
  // load_ack_o pulses together with frame_o. A strobe on the wrap cycle itself
  // bypasses staging and is acknowledged in that same cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stg_data <= '0;
      stg_mask <= '0;
      stg_lzb  <= 1'b0;
      sh_data  <= '0;
      sh_mask  <= '0;
      sh_lzb   <= 1'b0;
      pending  <= 1'b0;
    end else begin
      if (bus.load_i) begin
        stg_data <= bus.data_i;
        stg_mask <= bus.mask_i;
        stg_lzb  <= bus.lzb_i;
      end
      if (boundary) begin
        pending <= 1'b0;
        if (bus.load_i) begin
          sh_data <= bus.data_i;
          sh_mask <= bus.mask_i;
          sh_lzb  <= bus.lzb_i;
        end else if (pending) begin
          sh_data <= stg_data;
          sh_mask <= stg_mask;
          sh_lzb  <= stg_lzb;
        end
      end else if (bus.load_i) begin
        pending <= 1'b1;
      end
    end
  end

  assign frame_o        = boundary;
  assign bus.load_ack_o = boundary && (pending || bus.load_i);
  assign bus.pending_o  = pending;

  // Walk from the top digit down; a digit is zero-blanked while every nibble
  // at or above it is zero. Digit 0 always stays eligible.
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (sh_data[4*k +: 4] == 4'h0);
      if (k != 0) blank[k] = sh_lzb && zero_run;
    end
  end

  always_comb begin
    nib   = sh_data[4*int'(idx) +: 4];
    shown = sh_mask[idx] && !blank[idx];
    an_d  = '1;
    seg_d = 7'b1111111;
    if ((presc >= DEAD_END) && shown) begin
      an_d[idx] = 1'b0;
      seg_d     = seg_decode(nib);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      an_o  <= '1;
      seg_o <= 7'b1111111;
    end else begin
      an_o  <= an_d;
      seg_o <= seg_d;
    end
  end

endmodule

// File: doc/hex_scan_ctrl.md
Name: hex_scan_ctrl

Overview:
- Time-multiplexes DIGITS hex nibbles onto one shared 7-segment decoder and a common-anode multi-digit display.
- Sequences digit selection with a prescaler and inserts anti-ghosting dead time between digits.
- Applies per-digit enable masking and optional leading-zero blanking.
- Accepts new display contents via a load strobe and commits them only at a frame boundary, so a frame never shows mixed old and new data.

Parameters:
- DIGITS, 8, number of digits scanned; 2..8.
- PRESCALE, 100000, clock cycles per digit slot; ≥ 4.
- DEAD, 16, blanked cycles at the start of each slot; 1 ≤ DEAD < PRESCALE.

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  asynchronous active-low reset.
- data_i  in  4*DIGITS  nibbles; digit k = data_i[4k+3:4k]; digit 0 is rightmost.
- mask_i  in  DIGITS  per-digit enable; 1 = shown.
- lzb_i  in  1  leading-zero blanking enable.
- load_i  in  1  strobe; capture data_i/mask_i/lzb_i into staging.
- load_ack_o  out  1  one-cycle pulse when staged values are committed to the display.
- pending_o  out  1  staged values waiting for commit.
- frame_o  out  1  one-cycle pulse at each frame wrap.
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an_o  out  DIGITS  digit anodes, active-low.

Behaviour:
- Reset (async, rstn_i=0) clears:
  - prescaler = 0, digit index = 0;
  - staging and shadow data = 0, mask = 0, lzb = 0;
  - pending_o, load_ack_o, frame_o = 0;
  - seg_o = 7'b1111111, an_o = all 1.
- Prescaler counts 0..PRESCALE-1 and wraps. On wrap, the index increments.
- Frame boundary = prescaler wrap while index = DIGITS-1. On the boundary:
  - index returns to 0;
  - frame_o pulses in the same cycle as the wrap.
- Load strobe: load_i=1 in any cycle writes staging and sets pending_o next cycle. Repeated loads before commit overwrite staging; only the last one is applied.
- Commit at frame boundary with pending=1:
  - staging is copied to shadow, pending clears, load_ack_o pulses, coincident with frame_o.
- load_i on the boundary cycle: the new inputs go straight to shadow (bypass), load_ack_o pulses, pending stays 0.
- Display (registered outputs; each reflects the counter state one cycle earlier):
  - prescaler < DEAD: an_o all 1, seg_o = 1111111.
  - Otherwise: an_o[idx] = 0 only if shadow mask[idx]=1 and the digit is not blanked. All other an bits = 1.
  - seg_o = decode(shadow nibble[idx]) when the digit is shown, else 1111111.
- Leading-zero blanking (shadow lzb=1): digit k (k>0) is blanked if nibble k and every higher nibble are 0. Digit 0 is never zero-blanked.
- Decode table (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Frame length = DIGITS*PRESCALE cycles. No state other than the counters changes without load_i.

Test Plan (DIGITS=4, PRESCALE=8, DEAD=2):
- Reset: release rstn_i, no load → 32-cycle frame with an_o=1111, seg_o=1111111 throughout; frame_o pulses every 32 cycles.
- Load data_i=16'h12AF, mask=1111, lzb=0 mid-frame → pending_o=1 until boundary. load_ack_o and frame_o pulse together. Next frame, per slot: 2 blank cycles, then 6 cycles of:
  - an=1110 seg=0001110;
  - an=1101 seg=0001000;
  - an=1011 seg=0100100;
  - an=0111 seg=1111001.
- LZB: data 16'h0050, lzb=1, mask=1111 → digits 3,2 dark (an stays 1111); digit1 seg=0010010; digit0 seg=1000000. Data 16'h0000 → only digit0 lit, showing 1000000.
- Double load: load 16'h1111, then 16'h2222, both before the boundary → exactly one load_ack_o; display shows 2 (seg=0100100) on all digits.
- Load on boundary cycle (data 16'h3333): load_ack_o in the same cycle, pending_o stays 0; next frame shows 3 on all digits.
- Mask 0101, then assert rstn_i=0 mid-slot of digit 0 → while running, an_o[1] and an_o[3] are never 0; on reset, outputs go all-1 immediately, without waiting for a clock edge; after release, the scan restarts at digit 0 with prescaler 0.
